// File: rtl/lcd_mode_cmd_rx_pkg.sv
// Shared encodings for the LCD mode command receiver: display modes,
// command bytes, FSM state types and the oversample divider helper.
package lcd_cmd_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_FLASH  = 2'b10;

    localparam logic [7:0] CMD_MODE = 8'h4D;  // 'M'
    localparam logic [7:0] ARG_0    = 8'h30;  // '0'
    localparam logic [7:0] ARG_1    = 8'h31;  // '1'
    localparam logic [7:0] ARG_2    = 8'h32;  // '2'

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic       {P_IDLE, P_ARG}                   parse_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud,
                                             int unsigned oversample);
        return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
    endfunction

    function automatic logic is_arg(logic [7:0] b);
        return (b == ARG_0) || (b == ARG_1) || (b == ARG_2);
    endfunction

    // Only the three legal arguments reach here, so 2'b11 cannot be produced.
    function automatic logic [1:0] arg_to_mode(logic [7:0] b);
        case (b)
            ARG_1:   return MODE_BLINK;
            ARG_2:   return MODE_FLASH;
            default: return MODE_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/lcd_mode_cmd_rx_if.sv
// Serial line in, decoded mode and status pulses out; the receiver uses
// the slave view, the host/serial side uses the master view.
interface lcd_mode_cmd_rx_if;

    logic       rx_in;
    logic [1:0] mode;
    logic       mode_valid;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       cmd_err;

    modport master (
        output rx_in,
        input  mode, mode_valid, byte_valid, byte_data, frame_err, cmd_err
    );

    modport slave (
        input  rx_in,
        output mode, mode_valid, byte_valid, byte_data, frame_err, cmd_err
    );

endinterface

// File: rtl/lcd_mode_cmd_rx_uart_rx_core.sv
// 8N1 UART receiver: 2-flop line synchronizer, free-running oversample
// tick divider and a start/data/stop FSM sampling mid-bit.
module uart_rx_core
    import lcd_cmd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int          DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          OS_W  = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  MID_TICK  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  LAST_TICK = OS_W'(OVERSAMPLE - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    rx_state_e        state_q, state_d;
    logic [OS_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    // NOTE: sequential blocks use <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            div_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            div_q  <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    assign rx_s = sync_q[1];
    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= R_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // NOTE: every variable gets a default first, so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            R_IDLE: begin
                if (!rx_s) begin
                    state_d    = R_START;
                    tick_cnt_d = '0;
                end
            end
            R_START: begin
                if (tick) begin
                    if (tick_cnt_q == MID_TICK) begin
                        // A line back high at mid-start is a glitch, not a frame.
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? R_IDLE : R_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + OS_W'(1);
                    end
                end
            end
            R_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) state_d   = R_STOP;
                        else                   bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + OS_W'(1);
                    end
                end
            end
            R_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = '0;
                        state_d    = R_IDLE;
                        if (rx_s) begin
                            byte_data_d  = shift_q;
                            byte_valid_d = 1'b1;
                        end else begin
                            frame_err_d  = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + OS_W'(1);
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/lcd_mode_cmd_rx.sv
// Serial 'M'+digit command parser that holds the LCD display mode; the
// UART byte receiver is the uart_rx_core sub-module.
module lcd_mode_cmd_rx
    import lcd_cmd_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned FRAME_TIMEOUT = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_mode_cmd_rx_if.slave  bus_if
);

    localparam int             TO_W    = $clog2(FRAME_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_TIMEOUT - 1);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (bus_if.rx_in),
        .byte_valid_o (rx_valid),
        .byte_data_o  (rx_data),
        .frame_err_o  (rx_ferr)
    );

    parse_state_e    p_state_q, p_state_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [1:0]      mode_q, mode_d;
    logic            mode_valid_q, mode_valid_d;
    logic            cmd_err_q, cmd_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q    <= P_IDLE;
            timer_q      <= '0;
            mode_q       <= MODE_NORMAL;
            mode_valid_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            p_state_q    <= p_state_d;
            timer_q      <= timer_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_comb begin
        p_state_d    = p_state_q;
        timer_d      = '0;
        mode_d       = mode_q;
        mode_valid_d = 1'b0;
        cmd_err_d    = 1'b0;

        case (p_state_q)
            P_IDLE: begin
                if (rx_valid && (rx_data == CMD_MODE)) p_state_d = P_ARG;
            end
            P_ARG: begin
                // A byte landing on the expiry clock takes priority over the timeout.
                if (rx_valid) begin
                    if (is_arg(rx_data)) begin
                        mode_d       = arg_to_mode(rx_data);
                        mode_valid_d = 1'b1;
                        p_state_d    = P_IDLE;
                    end else if (rx_data != CMD_MODE) begin
                        cmd_err_d    = 1'b1;
                        p_state_d    = P_IDLE;
                    end
                end else if (rx_ferr) begin
                    p_state_d = P_IDLE;
                end else begin
                    timer_d = (timer_q == TO_LAST) ? timer_q : timer_q + TO_W'(1);
                    if (timer_d == TO_LAST) begin
                        cmd_err_d = 1'b1;
                        p_state_d = P_IDLE;
                        timer_d   = '0;
                    end
                end
            end
            default: p_state_d = P_IDLE;
        endcase
    end

    assign bus_if.mode       = mode_q;
    assign bus_if.mode_valid = mode_valid_q;
    assign bus_if.cmd_err    = cmd_err_q;
    assign bus_if.byte_valid = rx_valid;
    assign bus_if.byte_data  = rx_data;
    assign bus_if.frame_err  = rx_ferr;

endmodule
